addsub_flags_pipe: RTL and testbench

Two-stage pipelined 32-bit adder/subtractor that produces the sum/difference together with the negative, overflow, carry and zero condition flags consumed by the ALU's comparison stages (set-less-than signed/unsigned). It sits directly upstream of the SLT/SLTU result formers, which take `neg` and `ovf` from its output. The carry chain is split into two registered 16-bit halves so the 32-bit add meets timing. A valid/ready handshake on both sides supports back-pressure from the consuming stage.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/addsub16.sv | 13 +
 rtl/addsub_flags_pipe.sv | 113 +++++++++++
 tb/tb_addsub_flags_pipe.sv | 137 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants, flag bundle and overflow helper for the add/sub pipeline.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_HALF  = 16;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef struct packed {
    logic neg;
    logic ovf;
    logic carry;
    logic zero;
  } alu_flags_t;

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/addsub16.sv
// 16-bit adder with carry-in; bit 16 of the sum is the carry-out.
module addsub16
  import alu_pkg::*;
(
  input  logic [ALU_HALF-1:0] i_a,
  input  logic [ALU_HALF-1:0] i_b,
  input  logic                i_cin,
  output logic [ALU_HALF:0]   o_sum
);

  assign o_sum = {1'b0, i_a} + {1'b0, i_b} + {{ALU_HALF{1'b0}}, i_cin};

endmodule

// File: rtl/addsub_flags_pipe.sv
// Two-stage 32-bit add/sub with neg/ovf/carry/zero flags and valid/ready on both sides.
// Define ADDSUB_ZERO_FLAG_EN to compute the zero flag; otherwise it is tied to 0.
module addsub_flags_pipe
  import alu_pkg::*;
#(
  parameter int DELAY = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ALU_WIDTH-1:0] a,
  input  logic [ALU_WIDTH-1:0] b,
  input  logic                 op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ALU_WIDTH-1:0] result,
  output logic                 neg,
  output logic                 ovf,
  output logic                 carry,
  output logic                 zero
);

  // DELAY is a simulation annotation only; nothing in the logic depends on it.
  if (DELAY < 0) begin : g_delay_unused
  end

  logic [ALU_WIDTH-1:0] w_b_eff;
  logic [ALU_HALF:0]    w_lo;
  logic [ALU_HALF:0]    w_hi;
  logic                 w_s1_adv;
  logic                 w_s2_adv;
  logic                 w_zero;
  alu_flags_t           w_flags;

  logic                 r_s1_v;
  logic [ALU_HALF-1:0]  r_lo;
  logic                 r_c16;
  logic [ALU_HALF-1:0]  r_a_hi;
  logic [ALU_HALF-1:0]  r_b_hi;

  logic                 r_s2_v;
  logic [ALU_WIDTH-1:0] r_result;
  alu_flags_t           r_flags;

  assign w_b_eff  = (op == ALU_SUB) ? ~b : b;

  // A full stage may still move if the one ahead of it is moving this cycle.
  assign w_s2_adv = !r_s2_v || out_ready;
  assign w_s1_adv = !r_s1_v || w_s2_adv;
  assign in_ready = w_s1_adv;

  addsub16 u_lo (
    .i_a   (a[ALU_HALF-1:0]),
    .i_b   (w_b_eff[ALU_HALF-1:0]),
    .i_cin (op),
    .o_sum (w_lo)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_s1_v <= 1'b0;
    else if (w_s1_adv) r_s1_v <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (w_s1_adv && in_valid) begin
      r_lo   <= w_lo[ALU_HALF-1:0];
      r_c16  <= w_lo[ALU_HALF];
      r_a_hi <= a[ALU_WIDTH-1:ALU_HALF];
      r_b_hi <= w_b_eff[ALU_WIDTH-1:ALU_HALF];
    end
  end

  addsub16 u_hi (
    .i_a   (r_a_hi),
    .i_b   (r_b_hi),
    .i_cin (r_c16),
    .o_sum (w_hi)
  );

`ifdef ADDSUB_ZERO_FLAG_EN
  assign w_zero = ~|{w_hi[ALU_HALF-1:0], r_lo};
`else
  assign w_zero = 1'b0;
`endif

  assign w_flags.neg   = w_hi[ALU_HALF-1];
  assign w_flags.ovf   = signed_ovf(r_a_hi[ALU_HALF-1], r_b_hi[ALU_HALF-1], w_hi[ALU_HALF-1]);
  assign w_flags.carry = w_hi[ALU_HALF];
  assign w_flags.zero  = w_zero;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_v   <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else if (w_s2_adv) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_result <= {w_hi[ALU_HALF-1:0], r_lo};
        r_flags  <= w_flags;
      end
    end
  end

  assign out_valid = r_s2_v;
  assign result    = r_result;
  assign neg       = r_flags.neg;
  assign ovf       = r_flags.ovf;
  assign carry     = r_flags.carry;
  assign zero      = r_flags.zero;

endmodule

// File: tb/tb_addsub_flags_pipe.sv
// Directed self-checking bench for addsub_flags_pipe: arithmetic/flag vectors, back-pressure, mid-flight reset.
module tb_addsub_flags_pipe;

`ifdef ADDSUB_ZERO_FLAG_EN
  localparam logic ZEN = 1'b1;
`else
  localparam logic ZEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        op = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        neg, ovf, carry, zero;

  int n_checks = 0;
  int n_errors = 0;

  addsub_flags_pipe #(.DELAY(0)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .neg(neg), .ovf(ovf), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Flags compared as {neg, ovf, carry, zero}.
  task automatic do_op(input string tag, input logic o, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] er, input logic [3:0] ef);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = ia; b = ib;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_vld"},   {31'd0, out_valid}, 32'd1);
    chk({tag, "_res"},   result, er);
    chk({tag, "_flags"}, {28'd0, neg, ovf, carry, zero}, {28'd0, ef});
  endtask

  logic [31:0] bp_a   [4];
  logic [31:0] bp_b   [4];
  logic        bp_op  [4];
  logic [31:0] bp_exp [4];
  int idx_in, idx_out;

  initial begin
    // Reset state
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {28'd0, neg, ovf, carry, zero}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    #1 chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Arithmetic and flag vectors
    do_op("sub_3_5",     1'b1, 32'd3,        32'd5,        32'hFFFF_FFFE, 4'b1000);
    do_op("add_max_1",   1'b0, 32'h7FFF_FFFF, 32'd1,       32'h8000_0000, 4'b1100);
    do_op("sub_min_1",   1'b1, 32'h8000_0000, 32'd1,       32'h7FFF_FFFF, 4'b0110);
    do_op("add_c16",     1'b0, 32'h0000_FFFF, 32'd1,       32'h0001_0000, 4'b0000);
    do_op("add_wrap",    1'b0, 32'hFFFF_FFFF, 32'd1,       32'h0000_0000, {3'b001, ZEN});
    do_op("sub_eq",      1'b1, 32'd5,         32'd5,       32'h0000_0000, {3'b001, ZEN});
    do_op("add_plain",   1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 4'b0000);

    // Back-pressure: 4 back-to-back ops, out_ready low for 3 cycles
    bp_a[0] = 32'd10; bp_b[0] = 32'd20; bp_op[0] = 1'b0; bp_exp[0] = 32'd30;
    bp_a[1] = 32'd50; bp_b[1] = 32'd8;  bp_op[1] = 1'b1; bp_exp[1] = 32'd42;
    bp_a[2] = 32'h0001_FFFF; bp_b[2] = 32'd1; bp_op[2] = 1'b0; bp_exp[2] = 32'h0002_0000;
    bp_a[3] = 32'd0; bp_b[3] = 32'd1; bp_op[3] = 1'b1; bp_exp[3] = 32'hFFFF_FFFF;
    idx_in = 0; idx_out = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 3);
      in_valid  = (idx_in < 4);
      if (idx_in < 4) begin
        a = bp_a[idx_in]; b = bp_b[idx_in]; op = bp_op[idx_in];
      end
      #1;
      if (cyc == 0 || cyc == 1) chk("bp_in_ready_open", {31'd0, in_ready}, 32'd1);
      if (cyc == 2) chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
      if (cyc == 3) chk("bp_in_ready_drain", {31'd0, in_ready}, 32'd1);
      if (out_valid && out_ready) begin
        if (idx_out < 4) chk("bp_order", result, bp_exp[idx_out]);
        idx_out++;
      end
      if (in_valid && in_ready) idx_in++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_all_accepted", idx_in, 32'd4);
    chk("bp_all_emerged", idx_out, 32'd4);
    chk("bp_idle", {31'd0, out_valid}, 32'd0);

    // Reset with two ops in flight
    out_ready = 1'b0;
    in_valid = 1'b1; op = 1'b1; a = 32'd1; b = 32'd2;
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'd0; op = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rm_pre_valid", {31'd0, out_valid}, 32'd1);
    chk("rm_pre_res", result, 32'hFFFF_FFFF);
    reset_n = 1'b0;
    #1;
    chk("rm_valid", {31'd0, out_valid}, 32'd0);
    chk("rm_result", result, 32'd0);
    chk("rm_flags", {28'd0, neg, ovf, carry, zero}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rm_no_stale", {31'd0, out_valid}, 32'd0);
    end
    do_op("post_rst", 1'b0, 32'd1, 32'd2, 32'd3, 4'b0000);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
